// File: rtl/seg_scan_pkg.sv
// Shared types, constants and the on-window length helper for the seven-segment scanner.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    PH_BLANK = 2'd0,
    PH_ON    = 2'd1,
    PH_OFF   = 2'd2
  } scan_phase_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // (w * (brightness + 1)) >> duty_w, never below one cycle; product kept wide before the shift.
  function automatic int unsigned on_len_calc(input int unsigned w,
                                              input int unsigned brightness,
                                              input int unsigned duty_w);
    logic [63:0] prod;
    prod = 64'(w) * (64'(brightness) + 64'd1);
    prod = prod >> duty_w;
    if (prod == 64'd0) begin
      prod = 64'd1;
    end
    return 32'(prod);
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running modulo-DIV counter with an enable and a combinational wrap pulse.
module seg_tick_gen #(
  parameter int unsigned  DIV   = 2,
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_c_o
);

  if (DIV < 2) begin : g_bad_div
    $error("seg_tick_gen: DIV must be at least 2");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_c;

  always_comb begin
    wrap_c = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o  = cnt_q;
  assign wrap_c_o = wrap_c;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with dead time, PWM brightness,
// per-digit enable/blink and a frame-start strobe. All pins are registered.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned TICK_DIV     = 12500,
  parameter int unsigned BLANK_CYC    = 64,
  parameter int unsigned DUTY_W       = 4,
  parameter int unsigned BLINK_FRAMES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [DUTY_W-1:0]       brightness,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  if (NUM_DIGITS < 2) begin : g_bad_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be at least 2");
  end
  if (BLANK_CYC < 1) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYC must be at least 1");
  end
  if (TICK_DIV <= BLANK_CYC) begin : g_bad_div
    $error("seg_scan_ctrl: TICK_DIV must exceed BLANK_CYC");
  end
  if (DUTY_W < 1) begin : g_bad_duty
    $error("seg_scan_ctrl: DUTY_W must be at least 1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg_scan_ctrl: BLINK_FRAMES must be at least 1");
  end

  localparam int unsigned PC_W    = $clog2(TICK_DIV);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned END_W   = PC_W + 1;
  localparam int unsigned FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned WIN_CYC = TICK_DIV - BLANK_CYC;

  logic [PC_W-1:0]  pc;
  logic             pc_wrap_c;
  logic [IDX_W-1:0] idx;
  logic             idx_wrap_c;

  seg_tick_gen #(.DIV(TICK_DIV)) u_pc_gen (
    .clk      (clk),
    .reset    (reset),
    .en_i     (1'b1),
    .count_o  (pc),
    .wrap_c_o (pc_wrap_c)
  );

  seg_tick_gen #(.DIV(NUM_DIGITS)) u_idx_gen (
    .clk      (clk),
    .reset    (reset),
    .en_i     (pc_wrap_c),
    .count_o  (idx),
    .wrap_c_o (idx_wrap_c)
  );

  scan_phase_t          phase_q, phase_d;
  logic [6:0]           seg_lat_q, seg_lat_d;
  logic                 dp_lat_q, dp_lat_d;
  logic                 en_lat_q, en_lat_d;
  logic                 blink_lat_q, blink_lat_d;
  logic [DUTY_W-1:0]    bright_lat_q, bright_lat_d;
  logic [FC_W-1:0]      fc_q, fc_d;
  logic                 blink_q, blink_d;
  logic                 started_q, started_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                 fs_q, fs_d;
  logic [END_W-1:0]     on_end_c;
  logic                 visible_c;

  // Last pc of the lit window for the brightness latched in this slot.
  assign on_end_c = END_W'(BLANK_CYC)
                  + END_W'(on_len_calc(WIN_CYC, 32'(bright_lat_q), DUTY_W))
                  - END_W'(1);
  assign visible_c = en_lat_q & ~(blink_lat_q & blink_q);

  always_comb begin
    phase_d      = phase_q;
    seg_lat_d    = seg_lat_q;
    dp_lat_d     = dp_lat_q;
    en_lat_d     = en_lat_q;
    blink_lat_d  = blink_lat_q;
    bright_lat_d = bright_lat_q;
    fc_d         = fc_q;
    blink_d      = blink_q;
    started_d    = started_q;
    an_d         = '1;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    fs_d         = (pc == '0) && (idx == '0) && started_q;

    if (pc == '0) begin
      seg_lat_d    = seg_in[32'(idx) * 7 +: 7];
      dp_lat_d     = dp_in[idx];
      en_lat_d     = digit_en[idx];
      blink_lat_d  = blink_en[idx];
      bright_lat_d = brightness;
    end

    unique case (phase_q)
      PH_BLANK: if (pc == PC_W'(BLANK_CYC - 1)) phase_d = PH_ON;
      PH_ON: begin
        if (pc_wrap_c) begin
          phase_d = PH_BLANK;
        end else if ({1'b0, pc} == on_end_c) begin
          phase_d = PH_OFF;
        end
      end
      PH_OFF:   if (pc_wrap_c) phase_d = PH_BLANK;
      default:  phase_d = PH_BLANK;
    endcase

    if ((phase_q == PH_ON) && visible_c) begin
      an_d  = ~(NUM_DIGITS'(1) << idx);
      seg_d = seg_lat_q;
      dp_d  = ~dp_lat_q;
    end

    // Frame bookkeeping happens on the digit-index wrap back to 0.
    if (idx_wrap_c) begin
      started_d = 1'b1;
      if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
        fc_d    = '0;
        blink_d = ~blink_q;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= PH_BLANK;
      seg_lat_q    <= SEG_OFF;
      dp_lat_q     <= 1'b0;
      en_lat_q     <= 1'b0;
      blink_lat_q  <= 1'b0;
      bright_lat_q <= '0;
      fc_q         <= '0;
      blink_q      <= 1'b0;
      started_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      seg_lat_q    <= seg_lat_d;
      dp_lat_q     <= dp_lat_d;
      en_lat_q     <= en_lat_d;
      blink_lat_q  <= blink_lat_d;
      bright_lat_q <= bright_lat_d;
      fc_q         <= fc_d;
      blink_q      <= blink_d;
      started_q    <= started_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fs_q         <= fs_d;
    end
  end

  assign seg_n       = seg_q;
  assign dp_n        = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: per-slot vector table plus reset, mid-slot and latching sequences.
module tb_seg_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned TD = 32;
  localparam int unsigned BC = 4;
  localparam int unsigned DW = 2;
  localparam int unsigned BF = 2;
  localparam int FRAME = 128;

  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S0B = 7'h12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [27:0]   seg_in;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic [3:0]    blink_en;
  logic [1:0]    brightness;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [3:0]    an;
  logic          frame_start;

  int tests = 0;
  int failed = 0;
  int t = 0;

  typedef struct {
    logic [1:0] bright;
    logic [3:0] den;
    logic [3:0] ben;
    logic [3:0] dp;
    int         on_cyc;
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    logic       dp_exp;
  } slot_vec_t;

  slot_vec_t vecs[24];

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .TICK_DIV    (TD),
    .BLANK_CYC   (BC),
    .DUTY_W      (DW),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blink_en   (blink_en),
    .brightness (brightness),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an         (an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
    $fatal(1, "watchdog");
  end

  function automatic slot_vec_t mkv(input logic [1:0] b, input logic [3:0] den,
                                    input logic [3:0] ben, input logic [3:0] dp,
                                    input int on_cyc, input logic [3:0] an_e,
                                    input logic [6:0] seg_e, input logic dp_e);
    slot_vec_t v;
    v.bright = b; v.den = den; v.ben = ben; v.dp = dp;
    v.on_cyc = on_cyc; v.an_exp = an_e; v.seg_exp = seg_e; v.dp_exp = dp_e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s t=%0d got %h expected %h", name, t, act, exp);
    end
  endtask

  // Applies a slot's inputs before its latch edge, then checks all pins for each cycle of the slot.
  task automatic run_slot(input slot_vec_t v, input int chg_at,
                          input logic [1:0] chg_b, input logic [6:0] chg_seg);
    logic       lit;
    logic       fs_e;
    brightness = v.bright;
    digit_en   = v.den;
    blink_en   = v.ben;
    dp_in      = v.dp;
    for (int c = 0; c < int'(TD); c++) begin
      @(posedge clk);
      #1;
      lit  = (c >= int'(BC)) && (c < int'(BC) + v.on_cyc);
      fs_e = ((t % FRAME) == 0) && (t >= FRAME);
      check("an", 32'(an), lit ? 32'(v.an_exp) : 32'h0000000F);
      check("seg_n", 32'(seg_n), lit ? 32'(v.seg_exp) : 32'h0000007F);
      check("dp_n", 32'(dp_n), lit ? 32'(v.dp_exp) : 32'h00000001);
      check("frame_start", 32'(frame_start), 32'(fs_e));
      if (c == chg_at) begin
        brightness  = chg_b;
        seg_in[6:0] = chg_seg;
      end
      t++;
    end
  endtask

  initial begin
    seg_in     = {S3, S2, S1, S0};
    dp_in      = 4'h0;
    digit_en   = 4'hF;
    blink_en   = 4'h1;
    brightness = 2'd3;

    // Frame 0: full brightness
    vecs[0]  = mkv(2'd3, 4'hF, 4'h1, 4'h0, 28, 4'b1110, S0, 1'b1);
    vecs[1]  = mkv(2'd3, 4'hF, 4'h1, 4'h0, 28, 4'b1101, S1, 1'b1);
    vecs[2]  = mkv(2'd3, 4'hF, 4'h1, 4'h0, 28, 4'b1011, S2, 1'b1);
    vecs[3]  = mkv(2'd3, 4'hF, 4'h1, 4'h0, 28, 4'b0111, S3, 1'b1);
    // Frame 1: brightness 1, decimal point on digit 1
    vecs[4]  = mkv(2'd1, 4'hF, 4'h1, 4'h2, 14, 4'b1110, S0, 1'b1);
    vecs[5]  = mkv(2'd1, 4'hF, 4'h1, 4'h2, 14, 4'b1101, S1, 1'b0);
    vecs[6]  = mkv(2'd1, 4'hF, 4'h1, 4'h2, 14, 4'b1011, S2, 1'b1);
    vecs[7]  = mkv(2'd1, 4'hF, 4'h1, 4'h2, 14, 4'b0111, S3, 1'b1);
    // Frame 2: brightness 0, digit 2 disabled, digit 0 in blink-off phase
    vecs[8]  = mkv(2'd0, 4'hB, 4'h1, 4'h0, 0,  4'b1110, S0, 1'b1);
    vecs[9]  = mkv(2'd0, 4'hB, 4'h1, 4'h0, 7,  4'b1101, S1, 1'b1);
    vecs[10] = mkv(2'd0, 4'hB, 4'h1, 4'h0, 0,  4'b1011, S2, 1'b1);
    vecs[11] = mkv(2'd0, 4'hB, 4'h1, 4'h0, 7,  4'b0111, S3, 1'b1);
    // Frame 3: brightness 2, digit 0 still blinked off
    vecs[12] = mkv(2'd2, 4'hF, 4'h1, 4'h0, 0,  4'b1110, S0, 1'b1);
    vecs[13] = mkv(2'd2, 4'hF, 4'h1, 4'h0, 21, 4'b1101, S1, 1'b1);
    vecs[14] = mkv(2'd2, 4'hF, 4'h1, 4'h0, 21, 4'b1011, S2, 1'b1);
    vecs[15] = mkv(2'd2, 4'hF, 4'h1, 4'h0, 21, 4'b0111, S3, 1'b1);
    // Frames 4-5: digit 0 back on
    for (int f = 0; f < 2; f++) begin
      vecs[16 + 4*f] = mkv(2'd3, 4'hF, 4'h1, 4'h0, 28, 4'b1110, S0, 1'b1);
      vecs[17 + 4*f] = mkv(2'd3, 4'hF, 4'h1, 4'h0, 28, 4'b1101, S1, 1'b1);
      vecs[18 + 4*f] = mkv(2'd3, 4'hF, 4'h1, 4'h0, 28, 4'b1011, S2, 1'b1);
      vecs[19 + 4*f] = mkv(2'd3, 4'hF, 4'h1, 4'h0, 28, 4'b0111, S3, 1'b1);
    end

    // Outputs held dark while reset is asserted
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg_n", 32'(seg_n), 32'h0000007F);
    check("rst_dp_n", 32'(dp_n), 32'h00000001);
    check("rst_frame_start", 32'(frame_start), 32'h00000000);
    @(negedge clk);
    reset = 1'b0;
    t = 0;

    for (int i = 0; i < 24; i++) begin
      run_slot(vecs[i], -1, 2'd0, 7'h00);
    end

    // Mid-slot brightness and pattern change only show from the next slot of each digit
    run_slot(mkv(2'd3, 4'hF, 4'h0, 4'h0, 28, 4'b1110, S0, 1'b1), 10, 2'd0, S0B);
    run_slot(mkv(2'd0, 4'hF, 4'h0, 4'h0, 7,  4'b1101, S1, 1'b1), -1, 2'd0, 7'h00);
    run_slot(mkv(2'd0, 4'hF, 4'h0, 4'h0, 7,  4'b1011, S2, 1'b1), -1, 2'd0, 7'h00);
    run_slot(mkv(2'd0, 4'hF, 4'h0, 4'h0, 7,  4'b0111, S3, 1'b1), -1, 2'd0, 7'h00);
    run_slot(mkv(2'd0, 4'hF, 4'h0, 4'h0, 7,  4'b1110, S0B, 1'b1), -1, 2'd0, 7'h00);

    // Reset in the middle of digit 1's lit window, between clock edges
    brightness = 2'd3;
    repeat (10) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("pre_reset_an", 32'(an), 32'h0000000D);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'h0000000F);
    check("async_rst_seg_n", 32'(seg_n), 32'h0000007F);
    check("async_rst_dp_n", 32'(dp_n), 32'h00000001);
    check("async_rst_frame_start", 32'(frame_start), 32'h00000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    seg_in[6:0] = S0;
    reset = 1'b0;
    t = 0;

    // Scan restarts at digit 0 and the first frame has no frame_start
    run_slot(mkv(2'd3, 4'hF, 4'h0, 4'h0, 28, 4'b1110, S0, 1'b1), -1, 2'd0, 7'h00);
    run_slot(mkv(2'd3, 4'hF, 4'h0, 4'h0, 28, 4'b1101, S1, 1'b1), -1, 2'd0, 7'h00);
    run_slot(mkv(2'd3, 4'hF, 4'h0, 4'h0, 28, 4'b1011, S2, 1'b1), -1, 2'd0, 7'h00);
    run_slot(mkv(2'd3, 4'hF, 4'h0, 4'h0, 28, 4'b0111, S3, 1'b1), -1, 2'd0, 7'h00);
    run_slot(mkv(2'd3, 4'hF, 4'h0, 4'h0, 28, 4'b1110, S0, 1'b1), -1, 2'd0, 7'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
